// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mult_arbiter
//  Purpose  : Round-robin arbiter sharing one sequential 8x8 multiplier
//             between two requesters, with a WAIT-state timeout abort.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_a,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic        grant0,
    output logic        grant1,
    output logic        rsp_valid0,
    output logic        rsp_valid1,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        mult_start,
    output logic [7:0]  mult_dataa,
    output logic [7:0]  mult_datab,
    input  logic        mult_done,
    input  logic [15:0] mult_product,
    output logic        busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // Last WAIT count value; reaching it without a done aborts the operation.
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    // Bit 0: owner of the operation in flight. Bit 1: last granted requester.
    logic [1:0] r_owner;
    logic [7:0] r_cnt;

    logic w_req_any;
    logic w_winner;
    logic w_done_ok;
    logic w_timeout;
    logic w_finish;

    logic w_grant0;
    logic w_grant1;
    logic w_start;
    logic w_valid0;
    logic w_valid1;
    logic w_busy;

    assign w_req_any = req0 | req1;
    // Both asking: the one not served last wins. Otherwise the lone requester.
    assign w_winner  = (req0 & req1) ? ~r_owner[1] : req1;
    // A done on the first WAIT cycle may be left over from an earlier multiply.
    assign w_done_ok = mult_done & (r_cnt != 8'd0);
    assign w_timeout = (r_cnt == c_timeout_last);
    assign w_finish  = w_done_ok | w_timeout;

    // State register, registered outputs, timeout counter and datapath.
    always_ff @(posedge clk) begin
        if (reset_a) begin
            r_state    <= S_IDLE;
            r_owner    <= 2'b11;
            r_cnt      <= 8'd0;
            grant0     <= 1'b0;
            grant1     <= 1'b0;
            mult_start <= 1'b0;
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            busy       <= 1'b0;
            rsp_data   <= 16'd0;
            rsp_err    <= 1'b0;
            mult_dataa <= 8'd0;
            mult_datab <= 8'd0;
        end else begin
            r_state    <= w_next_state;
            grant0     <= w_grant0;
            grant1     <= w_grant1;
            mult_start <= w_start;
            rsp_valid0 <= w_valid0;
            rsp_valid1 <= w_valid1;
            busy       <= w_busy;

            if (w_grant0 | w_grant1) begin
                r_owner    <= {w_winner, w_winner};
                mult_dataa <= w_winner ? a1 : a0;
                mult_datab <= w_winner ? b1 : b0;
            end

            if (r_state == S_LAUNCH) begin
                r_cnt <= 8'd0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (r_state == S_WAIT) begin
                if (w_done_ok) begin
                    rsp_data <= mult_product;
                    rsp_err  <= 1'b0;
                end else if (w_timeout) begin
                    rsp_data <= 16'd0;
                    rsp_err  <= 1'b1;
                end
            end
        end
    end

    // Next-state decision.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_req_any) w_next_state = S_LAUNCH;
            S_LAUNCH: w_next_state = S_WAIT;
            S_WAIT:   if (w_finish) w_next_state = S_RESP;
            S_RESP:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; each appears one cycle after
    // the state in which it was decided.
    always_comb begin
        w_grant0 = (r_state == S_IDLE) & w_req_any & ~w_winner;
        w_grant1 = (r_state == S_IDLE) & w_req_any &  w_winner;
        w_start  = (r_state == S_LAUNCH);
        w_valid0 = (r_state == S_WAIT) & w_finish & ~r_owner[0];
        w_valid1 = (r_state == S_WAIT) & w_finish &  r_owner[0];
        w_busy   = (w_next_state != S_IDLE);
    end

endmodule
`default_nettype wire

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum WAIT-state cycles before abort, legal range 4..255.
REQ-002 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port reset_a  input  1  reset; synchronous, active-high.
REQ-004 Port req0 / req1  input  1 each  requester 0/1 asks for one multiply; held high until its grant pulse.
REQ-005 Port a0, b0 / a1, b1  input  8 each  requester operands; stable while the matching req is high.
REQ-006 Port grant0 / grant1  output  1 each  one-cycle pulse; operands of that requester are captured this cycle.
REQ-007 Port rsp_valid0 / rsp_valid1  output  1 each  one-cycle pulse; result for that requester is on rsp_data.
REQ-008 Port rsp_data  output  16  product of captured operands; 0 when rsp_err is high.
REQ-009 Port rsp_err  output  1  qualifies rsp_valid*; high means the multiply timed out.
REQ-010 Port mult_start  output  1  start pulse to the shared sequential 8x8 multiplier.
REQ-011 Port mult_dataa / mult_datab  output  8 each  registered operands driven to the multiplier; held from LAUNCH through WAIT.
REQ-012 Port mult_done  input  1  multiplier done flag.
REQ-013 Port mult_product  input  16  multiplier result; valid while mult_done is high.
REQ-014 Port busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, LAUNCH, WAIT and RESP, with a 2-bit owner/last-owner register.
REQ-016 IDLE: if any req is high, the block SHALL pick a winner, pulse its grant, latch its operands into mult_dataa/mult_datab, record the owner, and go to LAUNCH.
REQ-017 Arbitration SHALL be round-robin: with both req high, the winner is the requester not granted last; after reset, requester 0 wins first.
REQ-018 With a single req high, that requester SHALL win regardless of history.
REQ-019 LAUNCH SHALL last exactly one cycle, with mult_start=1, then go to WAIT; mult_start is 0 in all other states.
REQ-020 WAIT: a timeout counter SHALL clear on entry and increment each cycle; mult_done is ignored on the first WAIT cycle, because it can be stale from a previous operation.
REQ-021 WAIT: mult_done=1 (after the first WAIT cycle) SHALL capture mult_product into rsp_data, set rsp_err=0, and go to RESP.
REQ-022 WAIT: if the counter reaches TIMEOUT without a qualifying mult_done, the block SHALL set rsp_data=0 and rsp_err=1, then go to RESP; a done and a timeout in the same cycle count as done.
REQ-023 RESP SHALL last one cycle, pulse rsp_valid of the owner only, then return to IDLE; new grants are not issued in RESP.
REQ-024 rsp_data and rsp_err SHALL hold their last values until the next RESP.
REQ-025 Requests arriving during LAUNCH, WAIT or RESP SHALL wait; no grant is issued outside IDLE, and at most one grant is active per cycle.
REQ-026 Minimum req-to-rsp latency SHALL be grant cycle + 1 (LAUNCH) + WAIT cycles + 1 (RESP).
REQ-027 Throughput SHALL be one multiply in flight at a time; back-to-back requests are granted in the first IDLE cycle after RESP.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 When reset_a is high at a clock edge, the block SHALL enter IDLE; the timeout counter and rsp_data are cleared, and the last-owner register is set so that requester 0 wins next.
REQ-030 During reset, grant0, grant1, rsp_valid0, rsp_valid1, rsp_err, mult_start and busy SHALL be 0, and mult_dataa and mult_datab SHALL be 0.
REQ-031 Reset mid-operation (LAUNCH/WAIT/RESP) SHALL abort with no rsp_valid pulse; a later mult_done is ignored while in IDLE.

Verification
REQ-032 Single request: req0=1, a0=8'd12, b0=8'd11; multiplier model returns done after 5 cycles -> grant0 pulse, mult_start one cycle later, then rsp_valid0 with rsp_data=16'd132 and rsp_err=0.
REQ-033 Contention: req0 and req1 high together from reset with operands 255x255 and 3x7 -> grant0 first, rsp_data=16'd65025; then grant1, rsp_data=16'd21; rsp_valid1 only on the second response.
REQ-034 Round-robin fairness: both req held high for 4 operations -> grant order 0,1,0,1, never two consecutive grants to the same requester.
REQ-035 Timeout: TIMEOUT=15 and mult_done never asserted -> rsp_valid pulse after 15 WAIT cycles with rsp_err=1 and rsp_data=0, then IDLE.
REQ-036 Reset mid-WAIT: reset_a high for one cycle during WAIT, then mult_done pulses -> no rsp_valid, busy=0, and the next req1 alone receives a grant normally.
REQ-037 Stale done: mult_done held high continuously from before LAUNCH -> result is not captured on the first WAIT cycle, but is captured on the second.
